// File: rtl/attack_pkg.sv
// Shared encodings for the attack sequencer: phase codes, attack-type
// one-hot indices, 17-bit hitbox vectors and the knockback table.
package attack_pkg;

   typedef enum logic [1:0] {
      PH_IDLE     = 2'd0,
      PH_STARTUP  = 2'd1,
      PH_ACTIVE   = 2'd2,
      PH_RECOVERY = 2'd3
   } phase_t;

   localparam int NUM_TYPES = 10;

   // One-hot positions; attack[idx+1] on the output word
   localparam int T_SMASHU = 0;
   localparam int T_SMASHD = 1;
   localparam int T_SMASHL = 2;
   localparam int T_SMASHR = 3;
   localparam int T_JAB    = 4;
   localparam int T_SPECU  = 5;
   localparam int T_SPECD  = 6;
   localparam int T_SPECL  = 7;
   localparam int T_SPECR  = 8;
   localparam int T_SPECN  = 9;

   typedef logic [NUM_TYPES-1:0] atype_t;

   typedef struct packed {
      logic [16:0] x;
      logic [16:0] y;
   } vec17_t;

   // Subtraction that floors at zero instead of wrapping
   function automatic logic [16:0] satSub(
      input logic [16:0] a,
      input logic [16:0] b
   );
      return (a < b) ? 17'd0 : a - b;
   endfunction

   function automatic logic [31:0] knockbackOf(
      input atype_t t,
      input logic   faceRight
   );
      logic [31:0] kb;
      kb = 32'h0;
      unique case (1'b1)
         t[T_SMASHU]: kb = 32'h0000_0800;
         t[T_SMASHD]: kb = 32'h0000_F7FE;
         t[T_SMASHL]: kb = 32'hF7FE_00E0;
         t[T_SMASHR]: kb = 32'h0800_00E0;
         t[T_JAB]:    kb = faceRight ? 32'h0200_0100
                                     : 32'hFE00_0100;
         default:     kb = 32'h0;
      endcase
      return kb;
   endfunction

endpackage

// File: rtl/attack_sequencer_aabb.sv
// Strict axis-aligned box overlap test on 17-bit coordinates.
// Ports: apos/asize = box A origin/size, bpos/bsize = box B, hit = overlap.
module aabb_overlap
   import attack_pkg::*;
(
   input  vec17_t apos,
   input  vec17_t asize,
   input  vec17_t bpos,
   input  vec17_t bsize,
   output logic   hit
);

   logic [16:0] aRight;
   logic [16:0] bRight;
   logic [16:0] aTop;
   logic [16:0] bTop;

   assign aRight = apos.x + asize.x;
   assign bRight = bpos.x + bsize.x;
   assign aTop   = apos.y + asize.y;
   assign bTop   = bpos.y + bsize.y;

   assign hit = (apos.x < bRight) && (bpos.x < aRight)
             && (apos.y < bTop)   && (bpos.y < aTop);

endmodule

// File: rtl/attack_sequencer.sv
// Attack engine: decodes controls into one of ten attacks, runs
// STARTUP/ACTIVE/RECOVERY, builds a directional hitbox, one hit per attack.
// Ports: clock, reset (async, active-low); controls; char1/char2 pos+size;
// attack = {phase, active, type one-hot, hit}; knockback; movement.
module attack_sequencer
   import attack_pkg::*;
#(
   parameter int TIMER_W      = 8,
   parameter int STARTUP_CYC  = 4,
   parameter int ACTIVE_LONG  = 16,
   parameter int ACTIVE_SHORT = 6,
   parameter int RECOVERY_CYC = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] controls,
   input  logic [31:0] char1pos,
   input  logic [31:0] char1size,
   input  logic [31:0] char2pos,
   input  logic [31:0] char2size,
   output logic [31:0] attack,
   output logic [31:0] knockback,
   output logic [31:0] movement
);

   localparam logic [TIMER_W-1:0] LD_START = TIMER_W'(STARTUP_CYC - 1);
   localparam logic [TIMER_W-1:0] LD_LONG  = TIMER_W'(ACTIVE_LONG - 1);
   localparam logic [TIMER_W-1:0] LD_SHORT = TIMER_W'(ACTIVE_SHORT - 1);
   localparam logic [TIMER_W-1:0] LD_REC   = TIMER_W'(RECOVERY_CYC - 1);

   phase_t             state;
   phase_t             stateNext;
   logic [TIMER_W-1:0] cnt;
   logic [TIMER_W-1:0] cntNext;
   atype_t             typeQ;
   atype_t             typeNext;
   atype_t             reqType;
   logic               faceQ;
   logic               faceNext;
   logic               prevReq;
   logic               anyReq;
   logic               hitQ;
   logic               hitDone;
   logic               overlap;
   logic [31:0]        kbQ;
   logic [1:0]         phase;

   // ---- request decode ----
   logic [2:0] stickX;
   logic [2:0] stickY;
   logic       tiltL, tiltR, tiltU, tiltD;
   logic       btnA, btnB;
   logic       unusedCtl;

   assign stickX = controls[15:13];
   assign stickY = controls[7:5];
   assign tiltL  = (stickX == 3'b000);
   assign tiltR  = (stickX == 3'b111);
   assign tiltU  = (stickY == 3'b111);
   assign tiltD  = (stickY == 3'b000);
   assign btnA   = controls[16];
   assign btnB   = controls[17];

   assign unusedCtl = ^{controls[31:27], controls[25:24],
                        controls[19:18], controls[12:8],
                        controls[4:0]};

   always_comb begin
      reqType = '0;
      if (controls[23])        reqType[T_SMASHL] = 1'b1;
      else if (controls[22])   reqType[T_SMASHR] = 1'b1;
      else if (controls[21])   reqType[T_SMASHU] = 1'b1;
      else if (controls[20])   reqType[T_SMASHD] = 1'b1;
      else if (btnA)           reqType[T_JAB]    = 1'b1;
      else if (btnB && tiltL)  reqType[T_SPECL]  = 1'b1;
      else if (btnB && tiltR)  reqType[T_SPECR]  = 1'b1;
      else if (btnB && tiltU)  reqType[T_SPECU]  = 1'b1;
      else if (btnB && tiltD)  reqType[T_SPECD]  = 1'b1;
      else if (btnB)           reqType[T_SPECN]  = 1'b1;
   end

   assign anyReq = |reqType;

   // ---- phase sequencer ----
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      typeNext  = typeQ;
      faceNext  = faceQ;
      unique case (state)
         PH_IDLE: begin
            // edge-triggered: a held button must be released first
            if (anyReq && !prevReq) begin
               stateNext = PH_STARTUP;
               cntNext   = LD_START;
               typeNext  = reqType;
               faceNext  = controls[26];
            end
         end
         PH_STARTUP: begin
            if (cnt == '0) begin
               stateNext = PH_ACTIVE;
               cntNext   = typeQ[T_JAB] ? LD_SHORT : LD_LONG;
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         PH_ACTIVE: begin
            if (cnt == '0) begin
               stateNext = PH_RECOVERY;
               cntNext   = LD_REC;
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         PH_RECOVERY: begin
            if (cnt == '0) begin
               stateNext = PH_IDLE;
               typeNext  = '0;
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         default: stateNext = PH_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= PH_IDLE;
         cnt     <= '0;
         typeQ   <= '0;
         faceQ   <= 1'b0;
         prevReq <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         typeQ   <= typeNext;
         faceQ   <= faceNext;
         prevReq <= anyReq;
      end
   end

   // ---- hitbox geometry ----
   logic [16:0] x1, y1, w1, h1, hw, hh;
   vec17_t      boxL, boxR, boxU, boxD;
   vec17_t      hbPos, hbSize, c2Pos, c2Size;

   assign x1 = {1'b0, char1pos[31:16]};
   assign y1 = {1'b0, char1pos[15:0]};
   assign w1 = {1'b0, char1size[31:16]};
   assign h1 = {1'b0, char1size[15:0]};
   assign hw = w1 >> 1;
   assign hh = h1 >> 1;

   assign boxL = '{x: satSub(x1, hw),  y: y1 + (hh >> 1)};
   assign boxR = '{x: x1 + w1,         y: y1 + (hh >> 1)};
   assign boxU = '{x: x1 + (hw >> 1),  y: y1 + h1};
   assign boxD = '{x: x1 + (hw >> 1),  y: satSub(y1, hh >> 1)};

   assign hbSize = '{x: hw, y: hh};
   assign c2Pos  = '{x: {1'b0, char2pos[31:16]},
                     y: {1'b0, char2pos[15:0]}};
   assign c2Size = '{x: {1'b0, char2size[31:16]},
                     y: {1'b0, char2size[15:0]}};

   always_comb begin
      hbPos = boxR;
      unique case (1'b1)
         typeQ[T_SMASHL], typeQ[T_SPECL]: hbPos = boxL;
         typeQ[T_SMASHR], typeQ[T_SPECR]: hbPos = boxR;
         typeQ[T_SMASHU], typeQ[T_SPECU]: hbPos = boxU;
         typeQ[T_SMASHD], typeQ[T_SPECD]: hbPos = boxD;
         typeQ[T_JAB], typeQ[T_SPECN]:
            hbPos = faceQ ? boxR : boxL;
         default: hbPos = boxR;
      endcase
   end

   aabb_overlap uOverlap (
      .apos  (hbPos),
      .asize (hbSize),
      .bpos  (c2Pos),
      .bsize (c2Size),
      .hit   (overlap)
   );

   // ---- hit pulse and knockback ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hitQ    <= 1'b0;
         hitDone <= 1'b0;
         kbQ     <= 32'h0;
      end else begin
         hitQ <= 1'b0;
         if (state == PH_IDLE) begin
            hitDone <= 1'b0;
         end else if (state == PH_ACTIVE && overlap && !hitDone) begin
            hitQ    <= 1'b1;
            hitDone <= 1'b1;
            kbQ     <= knockbackOf(typeQ, faceQ);
         end
      end
   end

   assign phase     = state;
   assign attack    = {18'd0, phase, (state == PH_ACTIVE), typeQ, hitQ};
   assign knockback = kbQ;
   assign movement  = (state == PH_ACTIVE && typeQ[T_SPECU])
                    ? 32'h0000_0010 : 32'h0;

endmodule

// File: tb/tb_attack_sequencer.sv
// Scoreboard bench for attack_sequencer: stimulus pushes per-cycle
// expected outputs, a monitor pops and compares after each clock edge.
module tb_attack_sequencer;

   localparam logic [31:0] NEUT   = 32'h0000_8080;
   localparam logic [31:0] SM_L   = 32'h0080_0000;
   localparam logic [31:0] SM_R   = 32'h0040_0000;
   localparam logic [31:0] SM_U   = 32'h0020_0000;
   localparam logic [31:0] BTN_A  = 32'h0001_0000;
   localparam logic [31:0] FACE   = 32'h0400_0000;
   localparam logic [31:0] SPEC_U = 32'h0002_80E0;

   localparam logic [31:0] KB_SMR = 32'h0800_00E0;
   localparam logic [31:0] KB_SML = 32'hF7FE_00E0;
   localparam logic [31:0] KB_JBL = 32'hFE00_0100;

   logic        clock;
   logic        reset;
   logic [31:0] controls;
   logic [31:0] char1pos, char1size, char2pos, char2size;
   logic [31:0] attack, knockback, movement;

   typedef struct packed {
      int          tag;
      logic [31:0] a;
      logic [31:0] k;
      logic [31:0] m;
   } exp_t;

   exp_t q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   tagN       = 0;

   attack_sequencer #(
      .TIMER_W      (8),
      .STARTUP_CYC  (2),
      .ACTIVE_LONG  (4),
      .ACTIVE_SHORT (2),
      .RECOVERY_CYC (3)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .controls  (controls),
      .char1pos  (char1pos),
      .char1size (char1size),
      .char2pos  (char2pos),
      .char2size (char2size),
      .attack    (attack),
      .knockback (knockback),
      .movement  (movement)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic void check(
      input int tag,
      input logic [31:0] ga, gk, gm,
      input logic [31:0] ea, ek, em
   );
      compared++;
      if (ga !== ea || gk !== ek || gm !== em) begin
         mismatched++;
         $display("FAIL step%0d: attack=%h knockback=%h movement=%h, want %h %h %h",
                  tag, ga, gk, gm, ea, ek, em);
      end
   endfunction

   // attack word: hit bit, one type bit, active flag, phase code
   function automatic logic [31:0] aw(input bit h, input int tb, input int ph);
      logic [31:0] w;
      w = 32'h0;
      w[0] = h;
      w[tb] = 1'b1;
      w[11] = (ph == 2);
      w[13:12] = 2'(ph);
      return w;
   endfunction

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e.tag, attack, knockback, movement, e.a, e.k, e.m);
         end
      end
   end

   // drive one cycle of controls; expectation is for after the next edge
   task automatic cyc(input logic [31:0] ctl, input logic [31:0] ea,
                      input logic [31:0] ek, input logic [31:0] em);
      exp_t e;
      @(negedge clock);
      controls = ctl;
      e.tag = tagN;
      e.a = ea;
      e.k = ek;
      e.m = em;
      tagN++;
      q.push_back(e);
   endtask

   // 1-cycle press, STARTUP 2, ACTIVE nAct, RECOVERY 3, one IDLE cycle
   task automatic pressSeq(input logic [31:0] ctl, input int tb,
                           input int nAct, input bit hit,
                           input logic [31:0] kb0, input logic [31:0] kb1,
                           input logic [31:0] mov);
      cyc(ctl,  aw(0, tb, 1), kb0, 32'h0);
      cyc(NEUT, aw(0, tb, 1), kb0, 32'h0);
      for (int i = 0; i < nAct; i++)
         cyc(NEUT, aw(hit && i == 1, tb, 2),
             (hit && i >= 1) ? kb1 : kb0, mov);
      for (int i = 0; i < 3; i++)
         cyc(NEUT, aw(0, tb, 3), hit ? kb1 : kb0, 32'h0);
      cyc(NEUT, 32'h0, hit ? kb1 : kb0, 32'h0);
   endtask

   initial begin
      reset     = 1'b0;
      controls  = NEUT;
      char1pos  = {16'd100, 16'd100};
      char1size = {16'd16,  16'd32};
      char2pos  = {16'd118, 16'd110};
      char2size = {16'd4,   16'd4};

      repeat (2) @(negedge clock);
      check(900, attack, knockback, movement, 32'h0, 32'h0, 32'h0);
      reset = 1'b1;
      cyc(NEUT, 32'h0, 32'h0, 32'h0);

      // smashR, defender inside the right box
      pressSeq(NEUT | SM_R, 4, 4, 1, 32'h0, KB_SMR, 32'h0);

      // jab held 20 cycles facing left, defender inside the left box
      char2pos = {16'd94, 16'd110};
      for (int i = 0; i < 20; i++) begin
         if (i < 2)       cyc(NEUT | BTN_A, aw(0, 5, 1), KB_SMR, 32'h0);
         else if (i == 2) cyc(NEUT | BTN_A, aw(0, 5, 2), KB_SMR, 32'h0);
         else if (i == 3) cyc(NEUT | BTN_A, aw(1, 5, 2), KB_JBL, 32'h0);
         else if (i < 7)  cyc(NEUT | BTN_A, aw(0, 5, 3), KB_JBL, 32'h0);
         else             cyc(NEUT | BTN_A, 32'h0, KB_JBL, 32'h0);
      end
      cyc(NEUT, 32'h0, KB_JBL, 32'h0);
      // re-press facing right: right box misses the defender
      pressSeq(NEUT | BTN_A | FACE, 5, 2, 0, KB_JBL, KB_JBL, 32'h0);

      // smashL + smashU together, smashU pressed during RECOVERY
      cyc(NEUT | SM_L | SM_U, aw(0, 3, 1), KB_JBL, 32'h0);
      cyc(NEUT,        aw(0, 3, 1), KB_JBL, 32'h0);
      cyc(NEUT,        aw(0, 3, 2), KB_JBL, 32'h0);
      cyc(NEUT,        aw(1, 3, 2), KB_SML, 32'h0);
      cyc(NEUT,        aw(0, 3, 2), KB_SML, 32'h0);
      cyc(NEUT,        aw(0, 3, 2), KB_SML, 32'h0);
      cyc(NEUT,        aw(0, 3, 3), KB_SML, 32'h0);
      cyc(NEUT | SM_U, aw(0, 3, 3), KB_SML, 32'h0);
      cyc(NEUT | SM_U, aw(0, 3, 3), KB_SML, 32'h0);
      cyc(NEUT,        32'h0,       KB_SML, 32'h0);
      cyc(NEUT,        32'h0,       KB_SML, 32'h0);

      // left box clamps to X=0
      char1pos = {16'd2, 16'd100};
      char2pos = {16'd20, 16'd110};
      pressSeq(NEUT | SM_L, 3, 4, 0, KB_SML, KB_SML, 32'h0);
      char2pos  = {16'd0, 16'd110};
      char2size = {16'd1, 16'd4};
      pressSeq(NEUT | SM_L, 3, 4, 1, KB_SML, KB_SML, 32'h0);

      // specialU self-movement only while ACTIVE
      pressSeq(SPEC_U, 6, 4, 0, KB_SML, KB_SML, 32'h0000_0010);

      // reset in the middle of ACTIVE
      char1pos  = {16'd100, 16'd100};
      char2pos  = {16'd118, 16'd110};
      char2size = {16'd4,   16'd4};
      cyc(NEUT | SM_R, aw(0, 4, 1), KB_SML, 32'h0);
      cyc(NEUT,        aw(0, 4, 1), KB_SML, 32'h0);
      cyc(NEUT,        aw(0, 4, 2), KB_SML, 32'h0);
      cyc(NEUT,        aw(1, 4, 2), KB_SMR, 32'h0);
      @(negedge clock);
      reset = 1'b0;
      #1;
      check(901, attack, knockback, movement, 32'h0, 32'h0, 32'h0);
      @(negedge clock);
      check(902, attack, knockback, movement, 32'h0, 32'h0, 32'h0);
      reset = 1'b1;
      cyc(NEUT, 32'h0, 32'h0, 32'h0);
      pressSeq(NEUT | SM_R, 4, 4, 1, 32'h0, KB_SMR, 32'h0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
      #2;
      if (q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
